// File: rtl/gpu_batch_sequencer.sv
// Double-buffered draw-batch front end: queues batch commands, streams vertex
// reads to the vertex processor, collects transformed vertices into a
// ping-pong memory and hands each filled bank to the rasterizer.
//
// Fetch FSM
//   state   | meaning
//   F_IDLE  | waiting for a queued command and a FREE bank (zero-count commands dropped here)
//   F_FETCH | issuing one vertex read per cycle, base+i
//   F_DRAIN | all reads issued, waiting for the last transformed-vertex write
//
// Raster FSM
//   state   | meaning
//   R_IDLE  | waiting for the oldest bank to become FULL
//   R_RUN   | bank handed to rasterizer, waiting for rast_done
module gpu_batch_sequencer #(
    parameter int ADDR_W      = 14,
    parameter int CNT_W       = 32,
    parameter int DATA_W      = 11,
    parameter int QUEUE_DEPTH = 4,
    parameter int PRIM_VERTS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              cmd_last,
    output logic [ADDR_W-1:0] vtx_rd_addr,
    output logic              vtx_valid,
    input  logic              xf_valid,
    input  logic [DATA_W-1:0] xf_data,
    output logic              xf_wr_en,
    output logic [ADDR_W:0]   xf_wr_addr,
    output logic [DATA_W-1:0] xf_wr_data,
    output logic              rast_start,
    output logic              rast_bank,
    output logic [CNT_W-1:0]  rast_count,
    input  logic              rast_done,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        skipped,
    output logic              xf_overrun
);

    localparam int QA_W = $clog2(QUEUE_DEPTH);
    localparam int N_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PRIM_MASK  = ~CNT_W'(PRIM_VERTS - 1);
    localparam logic [CNT_W-1:0] BANK_DEPTH = CNT_W'(1) << ADDR_W;

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_RASTER} bank_st_t;
    typedef enum logic [1:0] {F_IDLE, F_FETCH, F_DRAIN} fetch_st_t;
    typedef enum logic {R_IDLE, R_RUN} rast_st_t;

    // command queue
    logic [ADDR_W-1:0] q_base [QUEUE_DEPTH];
    logic [N_W-1:0]    q_n    [QUEUE_DEPTH];
    logic              q_last [QUEUE_DEPTH];
    logic [QA_W:0]     q_wr_ptr, q_rd_ptr;
    logic              q_empty, q_full, ready_en, push, pop;
    logic [CNT_W-1:0]  cmd_masked;
    logic [N_W-1:0]    cmd_n;
    logic [ADDR_W-1:0] head_base;
    logic [N_W-1:0]    head_n;
    logic              head_last;

    // fetch side
    fetch_st_t         f_state, f_next;
    logic              alloc, drop, issue, fill_done;
    logic              alloc_bank, fill_bank, fill_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [N_W-1:0]    fetch_left, fill_n, wr_idx;
    logic              filling, xf_accept, xf_bad;

    // banks and raster side
    bank_st_t          bank_st   [2];
    logic [N_W-1:0]    bank_n    [2];
    logic              bank_last [2];
    rast_st_t          r_state, r_next;
    logic              rast_ptr, rast_free;

    // Round the requested count down to whole primitives and clamp to one bank.
    always_comb begin
        cmd_masked = cmd_count & PRIM_MASK;
        cmd_n      = (cmd_masked > BANK_DEPTH) ? N_W'(BANK_DEPTH) : N_W'(cmd_masked);
    end

    assign q_empty   = (q_wr_ptr == q_rd_ptr);
    assign q_full    = (q_wr_ptr[QA_W] != q_rd_ptr[QA_W]) &&
                       (q_wr_ptr[QA_W-1:0] == q_rd_ptr[QA_W-1:0]);
    assign cmd_ready = ready_en & ~q_full;
    assign push      = cmd_valid & cmd_ready;
    assign head_base = q_base[q_rd_ptr[QA_W-1:0]];
    assign head_n    = q_n[q_rd_ptr[QA_W-1:0]];
    assign head_last = q_last[q_rd_ptr[QA_W-1:0]];

    // Queue pointers; ready_en keeps cmd_ready low through the reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) q_wr_ptr <= q_wr_ptr + (QA_W+1)'(1);
            if (pop)  q_rd_ptr <= q_rd_ptr + (QA_W+1)'(1);
        end
    end

    // Queue storage, written on accept.
    always_ff @(posedge clk) begin
        if (push) begin
            q_base[q_wr_ptr[QA_W-1:0]] <= cmd_base;
            q_n[q_wr_ptr[QA_W-1:0]]    <= cmd_n;
            q_last[q_wr_ptr[QA_W-1:0]] <= cmd_last;
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) f_state <= F_IDLE;
        else       f_state <= f_next;
    end

    // Fetch FSM next state.
    always_comb begin
        f_next = f_state;
        case (f_state)
            F_IDLE:  if (!q_empty && head_n != '0 && bank_st[alloc_bank] == B_FREE) f_next = F_FETCH;
            F_FETCH: if (fetch_left == N_W'(1)) f_next = F_DRAIN;
            F_DRAIN: if (wr_idx == fill_n) f_next = F_IDLE;
            default: f_next = F_IDLE;
        endcase
    end

    // Fetch FSM outputs: queue pop/drop, bank allocation, read issue, fill completion.
    always_comb begin
        pop       = 1'b0;
        drop      = 1'b0;
        alloc     = 1'b0;
        issue     = 1'b0;
        fill_done = 1'b0;
        case (f_state)
            F_IDLE: begin
                if (!q_empty) begin
                    if (head_n == '0) begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end else if (bank_st[alloc_bank] == B_FREE) begin
                        pop   = 1'b1;
                        alloc = 1'b1;
                    end
                end
            end
            F_FETCH: issue = 1'b1;
            F_DRAIN: fill_done = (wr_idx == fill_n);
            default: ;
        endcase
    end

    assign vtx_rd_addr = rd_addr;

    // Read address generator with a down-counter for the remaining reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr    <= '0;
            fetch_left <= '0;
            fill_bank  <= 1'b0;
            fill_n     <= '0;
            fill_last  <= 1'b0;
            alloc_bank <= 1'b0;
            vtx_valid  <= 1'b0;
        end else begin
            vtx_valid <= issue;
            if (alloc) begin
                rd_addr    <= head_base;
                fetch_left <= head_n;
                fill_bank  <= alloc_bank;
                fill_n     <= head_n;
                fill_last  <= head_last;
                alloc_bank <= ~alloc_bank;
            end else if (issue) begin
                rd_addr    <= rd_addr + ADDR_W'(1);
                fetch_left <= fetch_left - N_W'(1);
            end
        end
    end

    // A write is legal only into the FILLING bank and only while it has room.
    always_comb begin
        filling   = (f_state != F_IDLE);
        xf_accept = xf_valid && filling && (wr_idx != fill_n);
        xf_bad    = xf_valid && !xf_accept;
    end

    // Registered transformed-vertex write port and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx     <= '0;
            xf_wr_en   <= 1'b0;
            xf_wr_addr <= '0;
            xf_wr_data <= '0;
            xf_overrun <= 1'b0;
        end else begin
            xf_wr_en <= xf_accept;
            if (xf_accept) begin
                xf_wr_addr <= {fill_bank, wr_idx[ADDR_W-1:0]};
                xf_wr_data <= xf_data;
            end
            if (alloc)          wr_idx <= '0;
            else if (xf_accept) wr_idx <= wr_idx + N_W'(1);
            if (xf_bad) xf_overrun <= 1'b1;
        end
    end

    // Bank lifecycle; the four events act on disjoint states so never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]   <= B_FREE;
                bank_n[b]    <= '0;
                bank_last[b] <= 1'b0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (alloc && alloc_bank == 1'(b)) begin
                    bank_st[b] <= B_FILLING;
                end else if (fill_done && fill_bank == 1'(b)) begin
                    bank_st[b]   <= B_FULL;
                    bank_n[b]    <= fill_n;
                    bank_last[b] <= fill_last;
                end else if (rast_start && rast_ptr == 1'(b)) begin
                    bank_st[b] <= B_RASTER;
                end else if (rast_free && rast_ptr == 1'(b)) begin
                    bank_st[b] <= B_FREE;
                end
            end
        end
    end

    // Raster FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Raster FSM next state.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (bank_st[rast_ptr] == B_FULL) r_next = R_RUN;
            R_RUN:   if (rast_done) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Raster FSM outputs; bank and count stay stable while the rasterizer runs.
    always_comb begin
        rast_start = (r_state == R_IDLE) && (bank_st[rast_ptr] == B_FULL);
        rast_free  = (r_state == R_RUN) && rast_done;
        rast_bank  = rast_ptr;
        rast_count = (rast_start || r_state == R_RUN) ? CNT_W'(bank_n[rast_ptr]) : '0;
    end

    // Raster bank pointer follows allocation order; frame_done marks the bank freeing.
    always_ff @(posedge clk) begin
        if (reset) begin
            rast_ptr   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= rast_free && bank_last[rast_ptr];
            if (rast_free) rast_ptr <= ~rast_ptr;
        end
    end

    // Saturating count of dropped zero-length commands.
    always_ff @(posedge clk) begin
        if (reset)                         skipped <= '0;
        else if (drop && skipped != 8'hFF) skipped <= skipped + 8'd1;
    end

    assign busy = !q_empty || (f_state != F_IDLE) ||
                  (bank_st[0] != B_FREE) || (bank_st[1] != B_FREE);

endmodule

// File: tb/tb_gpu_batch_sequencer.sv
// Scoreboard bench for gpu_batch_sequencer: models vertex memory, a fixed-latency
// vertex processor and a rasterizer with programmable hold time.
module tb_gpu_batch_sequencer;

    localparam int ADDR_W = 14;
    localparam int CNT_W  = 32;
    localparam int DATA_W = 11;
    localparam int LAT    = 3;

    typedef struct packed {
        logic [ADDR_W:0]   addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic             bank;
        logic [CNT_W-1:0] count;
        logic             last;
    } rs_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [CNT_W-1:0]  cmd_count = '0;
    logic              cmd_last = 1'b0;
    logic [ADDR_W-1:0] vtx_rd_addr;
    logic              vtx_valid;
    logic              xf_valid;
    logic [DATA_W-1:0] xf_data;
    logic              xf_wr_en;
    logic [ADDR_W:0]   xf_wr_addr;
    logic [DATA_W-1:0] xf_wr_data;
    logic              rast_start;
    logic              rast_bank;
    logic [CNT_W-1:0]  rast_count;
    logic              rast_done = 1'b0;
    logic              frame_done;
    logic              busy;
    logic [7:0]        skipped;
    logic              xf_overrun;

    int checks = 0;
    int failures = 0;

    logic [ADDR_W-1:0] exp_reads[$];
    wr_t               exp_writes[$];
    rs_t               exp_rast[$];
    int                gaps[$];
    logic              model_bank = 1'b0;
    int                exp_skipped = 0;

    int  cyc = 0;
    int  last_done_cyc = -1000;
    int  reads_seen = 0, writes_seen = 0, frames_seen = 0;
    int  rast_hold = 5;
    int  r_left = 0;
    bit  r_busy = 1'b0;
    bit  cur_bank = 1'b0, cur_last = 1'b0;
    bit  fd_pending = 1'b0, fd_val = 1'b0;
    bit  overlap_seen = 1'b0;
    bit  pv [LAT];
    logic [DATA_W-1:0] pd [LAT];
    logic              pv_out = 1'b0;
    logic [DATA_W-1:0] pd_out = '0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic              stray = 1'b0;
    logic [DATA_W-1:0] stray_data = '0;

    assign xf_valid = pv_out | stray;
    assign xf_data  = stray ? stray_data : pd_out;

    gpu_batch_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
        .cmd_count(cmd_count), .cmd_last(cmd_last),
        .vtx_rd_addr(vtx_rd_addr), .vtx_valid(vtx_valid),
        .xf_valid(xf_valid), .xf_data(xf_data),
        .xf_wr_en(xf_wr_en), .xf_wr_addr(xf_wr_addr), .xf_wr_data(xf_wr_data),
        .rast_start(rast_start), .rast_bank(rast_bank), .rast_count(rast_count),
        .rast_done(rast_done), .frame_done(frame_done),
        .busy(busy), .skipped(skipped), .xf_overrun(xf_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] xf_fn(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd5 + 32'd3;
        return t[DATA_W-1:0];
    endfunction

    // Environment: scoreboards, vertex processor pipeline, rasterizer model.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        wr_t ew;
        rs_t er;
        cyc++;

        if (vtx_valid === 1'b1) begin
            reads_seen++;
            checks++;
            if (exp_reads.size() == 0) begin
                failures++;
                $display("FAIL vtx_read unexpected got=%h", prev_addr);
            end else begin
                ea = exp_reads.pop_front();
                if (prev_addr !== ea) begin
                    failures++;
                    $display("FAIL vtx_read addr got=%h exp=%h", prev_addr, ea);
                end
            end
        end
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = vtx_valid;
        pd[0] = xf_fn(prev_addr);
        if (reset) for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        pv_out = pv[LAT-1];
        pd_out = pd[LAT-1];
        prev_addr = vtx_rd_addr;

        if (xf_wr_en === 1'b1) begin
            writes_seen++;
            checks++;
            if (r_busy && xf_wr_addr[ADDR_W] != cur_bank) overlap_seen = 1'b1;
            if (exp_writes.size() == 0) begin
                failures++;
                $display("FAIL xf_write unexpected addr=%h data=%h", xf_wr_addr, xf_wr_data);
            end else begin
                ew = exp_writes.pop_front();
                if (xf_wr_addr !== ew.addr || xf_wr_data !== ew.data) begin
                    failures++;
                    $display("FAIL xf_write got addr=%h data=%h exp addr=%h data=%h",
                             xf_wr_addr, xf_wr_data, ew.addr, ew.data);
                end
            end
        end

        if (fd_pending) begin
            checks++;
            if (frame_done !== fd_val) begin
                failures++;
                $display("FAIL frame_done got=%b exp=%b", frame_done, fd_val);
            end else if (fd_val) begin
                frames_seen++;
            end
            fd_pending = 1'b0;
        end else if (frame_done === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL frame_done unexpected got=1 exp=0");
        end

        rast_done = 1'b0;
        if (r_busy) begin
            if (r_left == 0) begin
                rast_done = 1'b1;
                r_busy = 1'b0;
                last_done_cyc = cyc;
                fd_pending = 1'b1;
                fd_val = cur_last;
            end else begin
                r_left--;
            end
        end
        if (rast_start === 1'b1) begin
            checks++;
            gaps.push_back(cyc - last_done_cyc);
            if (r_busy) begin
                failures++;
                $display("FAIL rast_start while running got=1 exp=0");
            end
            if (exp_rast.size() == 0) begin
                failures++;
                $display("FAIL rast_start unexpected bank=%0d count=%0d", rast_bank, rast_count);
            end else begin
                er = exp_rast.pop_front();
                if (rast_bank !== er.bank || rast_count !== er.count) begin
                    failures++;
                    $display("FAIL rast_start got bank=%0d count=%0d exp bank=%0d count=%0d",
                             rast_bank, rast_count, er.bank, er.count);
                end
                cur_last = er.last;
            end
            r_busy = 1'b1;
            r_left = rast_hold;
            cur_bank = rast_bank;
        end
        if (reset) begin
            r_busy = 1'b0;
            fd_pending = 1'b0;
            rast_done = 1'b0;
        end
    end

    task automatic send_cmd(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c, input logic l);
        int t = 0;
        logic [CNT_W-1:0] n;
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base = b;
        cmd_count = c;
        cmd_last = l;
        while (cmd_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept timeout base=%h", b);
            cmd_valid = 1'b0;
            return;
        end
        n = c & ~32'd3;
        if (n > 32'd16384) n = 32'd16384;
        if (n == 0) begin
            if (exp_skipped < 255) exp_skipped++;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + ADDR_W'(i);
                exp_reads.push_back(a);
                exp_writes.push_back('{addr: {model_bank, ADDR_W'(i)}, data: xf_fn(a)});
            end
            exp_rast.push_back('{bank: model_bank, count: n, last: l});
            model_bank = ~model_bank;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((busy || r_busy || fd_pending || exp_reads.size() != 0 ||
                exp_writes.size() != 0 || exp_rast.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= budget) begin
            failures++;
            $display("FAIL idle_timeout busy=%0b reads_left=%0d writes_left=%0d rast_left=%0d",
                     busy, exp_reads.size(), exp_writes.size(), exp_rast.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0;
        stray = 1'b0;
        repeat (2) @(negedge clk);
        exp_reads.delete();
        exp_writes.delete();
        exp_rast.delete();
        model_bank = 1'b0;
        exp_skipped = 0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
        checks++;
        if (busy !== 1'b0 || vtx_valid !== 1'b0 || xf_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got busy=%b vtx_valid=%b xf_wr_en=%b exp all 0", busy, vtx_valid, xf_wr_en);
        end
        checks++;
        if (rast_start !== 1'b0 || rast_count !== '0 || frame_done !== 1'b0 || rast_bank !== 1'b0) begin
            failures++;
            $display("FAIL reset_rast got start=%b count=%0d frame=%b bank=%b exp all 0",
                     rast_start, rast_count, frame_done, rast_bank);
        end
        checks++;
        if (skipped !== 8'd0 || xf_overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got skipped=%0d overrun=%b exp 0 0", skipped, xf_overrun);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_single();
        int r0, w0, f0;
        r0 = reads_seen; w0 = writes_seen; f0 = frames_seen;
        rast_hold = 5;
        send_cmd(14'd0, 32'd10, 1'b1);
        wait_idle(500);
        checks++;
        if (reads_seen - r0 != 8 || writes_seen - w0 != 8) begin
            failures++;
            $display("FAIL single_counts got reads=%0d writes=%0d exp 8 8", reads_seen - r0, writes_seen - w0);
        end
        checks++;
        if (frames_seen - f0 != 1) begin
            failures++;
            $display("FAIL single_frame got=%0d exp=1", frames_seen - f0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        gaps.delete();
        overlap_seen = 1'b0;
        rast_hold = 50;
        send_cmd(14'h100, 32'd8, 1'b0);
        send_cmd(14'h200, 32'd8, 1'b1);
        wait_idle(1000);
        checks++;
        if (overlap_seen !== 1'b1) begin
            failures++;
            $display("FAIL overlap got=%b exp=1", overlap_seen);
        end
        checks++;
        if (gaps.size() != 2 || gaps[1] != 1) begin
            failures++;
            $display("FAIL start_gap got size=%0d gap=%0d exp size=2 gap=1",
                     gaps.size(), (gaps.size() > 1) ? gaps[1] : -1);
        end
    endtask

    task automatic test_wrap();
        int r0;
        r0 = reads_seen;
        rast_hold = 3;
        send_cmd(14'h3FFE, 32'd4, 1'b0);
        wait_idle(500);
        checks++;
        if (reads_seen - r0 != 4) begin
            failures++;
            $display("FAIL wrap_reads got=%0d exp=4", reads_seen - r0);
        end
    endtask

    task automatic test_skip();
        do_reset();
        rast_hold = 3;
        send_cmd(14'h40, 32'd3, 1'b1);
        send_cmd(14'h50, 32'd4, 1'b1);
        wait_idle(500);
        checks++;
        if (skipped !== 8'(exp_skipped)) begin
            failures++;
            $display("FAIL skipped got=%0d exp=%0d", skipped, exp_skipped);
        end
    endtask

    task automatic test_queue_full();
        bit ok;
        do_reset();
        rast_hold = 400;
        send_cmd(14'h000, 32'd8, 1'b0);
        send_cmd(14'h020, 32'd8, 1'b0);
        repeat (40) @(negedge clk);
        for (int k = 0; k < 4; k++) send_cmd(14'(16'h0100 + 16'(k * 16)), 32'd8, 1'b0);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL queue_full_ready got=%b exp=0", cmd_ready);
        end
        cmd_valid = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0) ok = 1'b0;
        end
        cmd_valid = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL queue_refuse got ready=1 exp=0"); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL stalled_busy got=%b exp=1", busy); end
        rast_hold = 3;
        send_cmd(14'h200, 32'd8, 1'b1);
        wait_idle(3000);
    endtask

    task automatic test_overrun_and_reset();
        do_reset();
        @(negedge clk);
        stray = 1'b1;
        stray_data = 11'h5A5;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (xf_overrun !== 1'b1) begin failures++; $display("FAIL overrun got=%b exp=1", xf_overrun); end

        do_reset();
        checks++;
        if (xf_overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", xf_overrun); end
        rast_hold = 3;
        send_cmd(14'h300, 32'd64, 1'b1);
        send_cmd(14'h400, 32'd8, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (vtx_valid !== 1'b1) begin failures++; $display("FAIL mid_fetch_valid got=%b exp=1", vtx_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (vtx_valid !== 1'b0 || busy !== 1'b0 || xf_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got vtx_valid=%b busy=%b xf_wr_en=%b exp 0 0 0", vtx_valid, busy, xf_wr_en);
        end
        exp_reads.delete();
        exp_writes.delete();
        exp_rast.delete();
        model_bank = 1'b0;
        exp_skipped = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_mid_reset got ready=%b busy=%b exp 1 0", cmd_ready, busy);
        end
        send_cmd(14'h010, 32'd4, 1'b1);
        wait_idle(500);
        checks++;
        if (xf_overrun !== 1'b0) begin failures++; $display("FAIL stale_overrun got=%b exp=0", xf_overrun); end
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_skip();
        test_queue_full();
        test_overrun_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
